debounce_botones: RTL

- Upstream conditioning stage for the ALU top's button bus. Takes the raw, bouncy, asynchronous push-buttons and synchronises and debounces each one.
- Emits a strictly one-hot, single-cycle press pulse per validated press. The ALU top then latches operand A, operand B or the opcode exactly once per physical press.
- Also exports the debounced button levels for LEDs and debug.

---
 rtl/debounce_botones_pkg.sv | 20 ++
 rtl/debounce_boton.sv | 134 +++++++++++++
 rtl/debounce_botones.sv | 51 +++++
 3 files changed

// File: rtl/debounce_botones_pkg.sv
// Shared definitions for the button debouncer: default bus width, default
// stability / auto-repeat periods and the per-button FSM state encoding.
package debounce_botones_pkg;

    // Default width of the button bus (matches the ALU top).
    localparam int CANT_BOTONES_DEF      = 4;
    // 1 ms of stable level at 100 MHz.
    localparam int CICLOS_ESTABLE_DEF    = 100000;
    // 250 ms auto-repeat period at 100 MHz (only with DEBOUNCE_AUTOREPEAT_EN).
    localparam int CICLOS_REPETICION_DEF = 25000000;

    // Per-button debounce FSM states.
    typedef enum logic [1:0] {
        SOLTADO           = 2'd0,
        VALIDANDO_PRESION = 2'd1,
        PRESIONADO        = 2'd2,
        VALIDANDO_SUELTA  = 2'd3
    } estado_boton_t;

endpackage

// File: rtl/debounce_boton.sv
// Single-button conditioner: 2-FF synchroniser, debounce FSM with stability
// counter, registered debounced level and a one-cycle press request.
// Optional auto-repeat while held: define DEBOUNCE_AUTOREPEAT_EN.
module debounce_boton
    import debounce_botones_pkg::*;
#(
    parameter int CICLOS_ESTABLE    = CICLOS_ESTABLE_DEF,
    parameter int CICLOS_REPETICION = CICLOS_REPETICION_DEF
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_boton,
    output logic o_nivel,
    output logic o_pedido
);

    localparam int ANCHO_CNT = $clog2(CICLOS_ESTABLE);
    localparam logic [ANCHO_CNT-1:0] CNT_FIN = ANCHO_CNT'(CICLOS_ESTABLE - 1);

    // Both periods must allow at least one counting step.
    if (CICLOS_ESTABLE < 2 || CICLOS_REPETICION < 2) begin : g_rango_invalido
        $error("debounce_boton: CICLOS_ESTABLE and CICLOS_REPETICION must be >= 2");
    end

    logic [1:0]           sync_q;
    logic                 s;
    estado_boton_t        estado_q;
    logic [ANCHO_CNT-1:0] cnt_q;
    logic                 nivel_q;
    logic                 pedido_presion;
    logic                 pedido_rep;

    // Two-flop synchroniser for the asynchronous raw button.
    // NOTE: state flops use <= so every register samples pre-edge values; with = the second flop would copy the first in the same edge and the synchroniser would collapse to one stage.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], i_boton};
        end
    end

    assign s = sync_q[1];

    // Debounce FSM: a level is accepted after CICLOS_ESTABLE consecutive samples.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            estado_q <= SOLTADO;
            cnt_q    <= '0;
            nivel_q  <= 1'b0;
        end else begin
            case (estado_q)
                SOLTADO: begin
                    if (s) begin
                        estado_q <= VALIDANDO_PRESION;
                        cnt_q    <= ANCHO_CNT'(1);
                    end
                end
                VALIDANDO_PRESION: begin
                    if (!s) begin
                        estado_q <= SOLTADO;
                        cnt_q    <= '0;
                    end else if (cnt_q == CNT_FIN) begin
                        estado_q <= PRESIONADO;
                        cnt_q    <= '0;
                        nivel_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + ANCHO_CNT'(1);
                    end
                end
                PRESIONADO: begin
                    if (!s) begin
                        estado_q <= VALIDANDO_SUELTA;
                        cnt_q    <= ANCHO_CNT'(1);
                    end
                end
                VALIDANDO_SUELTA: begin
                    if (s) begin
                        estado_q <= PRESIONADO;
                        cnt_q    <= '0;
                    end else if (cnt_q == CNT_FIN) begin
                        estado_q <= SOLTADO;
                        cnt_q    <= '0;
                        nivel_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + ANCHO_CNT'(1);
                    end
                end
                default: begin
                    estado_q <= SOLTADO;
                    cnt_q    <= '0;
                    nivel_q  <= 1'b0;
                end
            endcase
        end
    end

    // The request is decoded from registered state and the synchronised bit
    // so the top's pulse register fires on the same edge the press is
    // accepted; it never sees the raw input combinationally.
    assign pedido_presion = (estado_q == VALIDANDO_PRESION) && s && (cnt_q == CNT_FIN);

`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam int ANCHO_REP = $clog2(CICLOS_REPETICION);
    localparam logic [ANCHO_REP-1:0] REP_FIN = ANCHO_REP'(CICLOS_REPETICION - 1);

    logic [ANCHO_REP-1:0] rep_q;
    logic                 entra_pres;

    assign entra_pres = s && (((estado_q == VALIDANDO_PRESION) && (cnt_q == CNT_FIN)) ||
                              (estado_q == VALIDANDO_SUELTA));

    // Repeat timer: restarts on every entry to PRESIONADO, runs while held.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            rep_q <= '0;
        end else if (entra_pres) begin
            rep_q <= '0;
        end else if (nivel_q) begin
            rep_q <= (rep_q == REP_FIN) ? '0 : rep_q + ANCHO_REP'(1);
        end else begin
            rep_q <= '0;
        end
    end

    assign pedido_rep = (estado_q == PRESIONADO) && (rep_q == REP_FIN);
`else
    assign pedido_rep = 1'b0;
`endif

    assign o_nivel  = nivel_q;
    assign o_pedido = pedido_presion | pedido_rep;

endmodule

// File: rtl/debounce_botones.sv
// Button-bus conditioner for the ALU top: one debouncer per button, a
// lowest-index priority arbiter and a registered one-hot press pulse.
// Optional auto-repeat while held: define DEBOUNCE_AUTOREPEAT_EN.
module debounce_botones
    import debounce_botones_pkg::*;
#(
    parameter int CANT_BOTONES      = CANT_BOTONES_DEF,
    parameter int CICLOS_ESTABLE    = CICLOS_ESTABLE_DEF,
    parameter int CICLOS_REPETICION = CICLOS_REPETICION_DEF
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic [CANT_BOTONES-1:0] i_botones,
    output logic [CANT_BOTONES-1:0] o_pulsos,
    output logic [CANT_BOTONES-1:0] o_estado
);

    logic [CANT_BOTONES-1:0] pedidos;
    logic [CANT_BOTONES-1:0] niveles;
    logic [CANT_BOTONES-1:0] pulso_sig;
    logic [CANT_BOTONES-1:0] pulsos_q;

    for (genvar i = 0; i < CANT_BOTONES; i++) begin : g_boton
        debounce_boton #(
            .CICLOS_ESTABLE    (CICLOS_ESTABLE),
            .CICLOS_REPETICION (CICLOS_REPETICION)
        ) u_boton (
            .i_clock  (i_clock),
            .i_reset  (i_reset),
            .i_boton  (i_botones[i]),
            .o_nivel  (niveles[i]),
            .o_pedido (pedidos[i])
        );
    end

    // Keep only the lowest-index request; the rest are dropped, not queued.
    assign pulso_sig = pedidos & (~pedidos + CANT_BOTONES'(1));

    // Registered pulse output, cleared by reset.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            pulsos_q <= '0;
        end else begin
            pulsos_q <= pulso_sig;
        end
    end

    assign o_pulsos = pulsos_q;
    assign o_estado = niveles;

endmodule
